// File: rtl/quad_decoder_pkg.sv
// Shared constants and move classification for the quadrature decoder.
package quad_decoder_pkg;

   // Direction encodings reported on the dir output
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Stable phase pair encodings, written as {a,b}
   localparam logic [1:0] PAIR_00 = 2'b00;
   localparam logic [1:0] PAIR_01 = 2'b01;
   localparam logic [1:0] PAIR_10 = 2'b10;
   localparam logic [1:0] PAIR_11 = 2'b11;

   // Outcome of comparing the previous and current stable pairs
   typedef enum logic [1:0] {
      MOVE_NONE    = 2'b00,
      MOVE_UP      = 2'b01,
      MOVE_DOWN    = 2'b10,
      MOVE_ILLEGAL = 2'b11
   } move_e;

   // Gray-code walk 00->10->11->01->00 counts up; the reverse walk counts down.
   // Any change of both bits at once cannot come from a real rotation.
   function automatic move_e classify_move(input logic [1:0] prev_pair,
                                           input logic [1:0] cur_pair);
      move_e move;
      move = MOVE_ILLEGAL;
      case ({prev_pair, cur_pair})
         {PAIR_00, PAIR_00},
         {PAIR_01, PAIR_01},
         {PAIR_10, PAIR_10},
         {PAIR_11, PAIR_11}: move = MOVE_NONE;
         {PAIR_00, PAIR_10},
         {PAIR_10, PAIR_11},
         {PAIR_11, PAIR_01},
         {PAIR_01, PAIR_00}: move = MOVE_UP;
         {PAIR_10, PAIR_00},
         {PAIR_11, PAIR_10},
         {PAIR_01, PAIR_11},
         {PAIR_00, PAIR_01}: move = MOVE_DOWN;
         default:            move = MOVE_ILLEGAL;
      endcase
      return move;
   endfunction

endpackage

// File: rtl/quad_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer for one encoder phase.
module quad_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_stable
);

   // The counter runs while the synchronized input disagrees with the stable level;
   // the new level is taken on the edge where the count would reach DEBOUNCE_CYCLES.
   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic       r_sync1;
   logic       r_sync2;
   logic       r_stable;
   logic [7:0] r_cnt;

   // Synchronize the raw input and qualify changes that stay put long enough
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= 8'd0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_stable) begin
            r_cnt <= 8'd0;
         end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= 8'd0;
         end else begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   assign o_stable = r_stable;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: debounced phases feed a Gray-code step detector
// and an up/down counter that either saturates or wraps.
module quad_decoder
   import quad_decoder_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SATURATE        = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enc_a,
   input  logic             enc_b,
   input  logic             clear,
   output logic [WIDTH-1:0] value,
   output logic             step,
   output logic             dir,
   output logic             err
);

   localparam logic [WIDTH-1:0] VALUE_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] VALUE_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] VALUE_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic             w_stable_a;
   logic             w_stable_b;
   logic [1:0]       w_cur_pair;
   move_e            w_move;
   logic [WIDTH-1:0] w_next_value;
   logic             w_next_step;
   logic             w_next_dir;
   logic             w_next_err;

   logic [1:0]       r_prev_pair;
   logic [WIDTH-1:0] r_value;
   logic             r_step;
   logic             r_dir;
   logic             r_err;

   quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
      .clk      (clk),
      .reset    (reset),
      .i_raw    (enc_a),
      .o_stable (w_stable_a)
   );

   quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
      .clk      (clk),
      .reset    (reset),
      .i_raw    (enc_b),
      .o_stable (w_stable_b)
   );

   assign w_cur_pair = {w_stable_a, w_stable_b};
   assign w_move     = classify_move(r_prev_pair, w_cur_pair);

   // Work out the next count, step pulse, direction and error pulse from the move
   always_comb begin
      w_next_value = r_value;
      w_next_step  = 1'b0;
      w_next_dir   = r_dir;
      w_next_err   = 1'b0;
      case (w_move)
         MOVE_UP: begin
            w_next_dir = DIR_UP;
            if (r_value != VALUE_MAX) begin
               w_next_value = r_value + VALUE_ONE;
               w_next_step  = 1'b1;
            end else if (SATURATE == 0) begin
               w_next_value = VALUE_ZERO;
               w_next_step  = 1'b1;
            end else begin
               w_next_value = r_value;
            end
         end
         MOVE_DOWN: begin
            w_next_dir = DIR_DOWN;
            if (r_value != VALUE_ZERO) begin
               w_next_value = r_value - VALUE_ONE;
               w_next_step  = 1'b1;
            end else if (SATURATE == 0) begin
               w_next_value = VALUE_MAX;
               w_next_step  = 1'b1;
            end else begin
               w_next_value = r_value;
            end
         end
         MOVE_ILLEGAL: begin
            w_next_err = 1'b1;
         end
         default: begin
            w_next_err = 1'b0;
         end
      endcase
      // clear wins over any coincident rotation and suppresses its step pulse
      if (clear) begin
         w_next_value = VALUE_ZERO;
         w_next_step  = 1'b0;
      end else begin
         w_next_step  = w_next_step;
      end
   end

   // Register the decoded outputs and remember the pair for the next comparison
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev_pair <= PAIR_00;
         r_value     <= VALUE_ZERO;
         r_step      <= 1'b0;
         r_dir       <= DIR_DOWN;
         r_err       <= 1'b0;
      end else begin
         r_prev_pair <= w_cur_pair;
         r_value     <= w_next_value;
         r_step      <= w_next_step;
         r_dir       <= w_next_dir;
         r_err       <= w_next_err;
      end
   end

   assign value = r_value;
   assign step  = r_step;
   assign dir   = r_dir;
   assign err   = r_err;

endmodule
